// File: rtl/bram_bank.sv
// Single-port-write / single-port-read block RAM bank with power-up zero-fill,
// selectable read-during-write behaviour and an optional output pipeline.
module bram_bank #(
  parameter int DATA_SZ        = 16,
  parameter int ADDR_SZ        = 8,
  parameter int MEM_MAX        = (1 << ADDR_SZ),
  parameter int RD_MODE        = 0,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  output logic               o_ready,
  input  logic               i_wr_en,
  input  logic [ADDR_SZ-1:0] i_waddr,
  input  logic [DATA_SZ-1:0] i_wdata,
  input  logic               i_rd_en,
  input  logic [ADDR_SZ-1:0] i_raddr,
  output logic [DATA_SZ-1:0] o_rdata,
  output logic               o_rd_valid
);

  localparam int IDX_SZ = (MEM_MAX > 1) ? $clog2(MEM_MAX) : 1;
  localparam int CNT_SZ = ADDR_SZ + 1;
  localparam logic [CNT_SZ-1:0] MEM_LIM = CNT_SZ'(MEM_MAX);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t              state_reg;
  logic [CNT_SZ-1:0]   clr_cnt_reg;
  logic                ready_reg;

  logic                clr_we;
  logic                wr_ok;
  logic                rd_fire;
  logic                rd_in_range;
  logic                mem_we;
  logic [IDX_SZ-1:0]   mem_widx;
  logic [IDX_SZ-1:0]   rd_idx;
  logic [DATA_SZ-1:0]  mem_wdat;

  logic [DATA_SZ-1:0]  mem [MEM_MAX];
  logic [DATA_SZ-1:0]  mem_rd_reg;

  logic                rd_vld_reg;
  logic                rd_hit_reg;
  logic                byp_sel_reg;
  logic [DATA_SZ-1:0]  byp_data_reg;
  logic [DATA_SZ-1:0]  s0_data;
  logic                s0_vld;

  // The counter runs one step past the last address so READY follows the final clear write.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg   <= ST_CLEAR;
      clr_cnt_reg <= '0;
      ready_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_CLEAR: begin
          if ((CLEAR_ON_RESET == 0) || (clr_cnt_reg == MEM_LIM)) begin
            state_reg <= ST_READY;
            ready_reg <= 1'b1;
          end else begin
            clr_cnt_reg <= clr_cnt_reg + 1'b1;
          end
        end
        ST_READY: begin
          state_reg <= ST_READY;
          ready_reg <= 1'b1;
        end
        default: begin
          state_reg <= ST_CLEAR;
          ready_reg <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready     = ready_reg;
  assign clr_we      = (state_reg == ST_CLEAR) && (CLEAR_ON_RESET != 0) && (clr_cnt_reg < MEM_LIM);
  assign wr_ok       = ready_reg && i_wr_en && ({1'b0, i_waddr} < MEM_LIM);
  assign rd_fire     = ready_reg && i_rd_en;
  assign rd_in_range = ({1'b0, i_raddr} < MEM_LIM);
  assign mem_we      = clr_we || wr_ok;
  assign mem_widx    = clr_we ? clr_cnt_reg[IDX_SZ-1:0] : i_waddr[IDX_SZ-1:0];
  assign mem_wdat    = clr_we ? '0 : i_wdata;
  assign rd_idx      = i_raddr[IDX_SZ-1:0];

  // No reset on the array or its read register so the tools map them onto block RAM.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem[mem_widx] <= mem_wdat;
    end
    if (rd_fire) begin
      mem_rd_reg <= mem[rd_idx];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_vld_reg   <= 1'b0;
      rd_hit_reg   <= 1'b0;
      byp_sel_reg  <= 1'b0;
      byp_data_reg <= '0;
    end else begin
      rd_vld_reg <= rd_fire;
      if (rd_fire) begin
        rd_hit_reg   <= rd_in_range;
        byp_sel_reg  <= (RD_MODE != 0) && wr_ok && (i_waddr == i_raddr);
        byp_data_reg <= i_wdata;
      end
    end
  end

  // Out-of-range reads return zero; the RAM output is only trusted after an in-range read.
  assign s0_data = !rd_hit_reg ? '0 : (byp_sel_reg ? byp_data_reg : mem_rd_reg);
  assign s0_vld  = rd_vld_reg;

  generate
    if (OUT_REG == 0) begin : g_no_oreg
      assign o_rdata    = s0_data;
      assign o_rd_valid = s0_vld;
    end else begin : g_oreg
      logic [DATA_SZ-1:0] pd_reg [OUT_REG];
      logic               pv_reg [OUT_REG];

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          for (int i = 0; i < OUT_REG; i++) begin
            pd_reg[i] <= '0;
            pv_reg[i] <= 1'b0;
          end
        end else begin
          pv_reg[0] <= s0_vld;
          if (s0_vld) begin
            pd_reg[0] <= s0_data;
          end
          for (int i = 1; i < OUT_REG; i++) begin
            pv_reg[i] <= pv_reg[i-1];
            if (pv_reg[i-1]) begin
              pd_reg[i] <= pd_reg[i-1];
            end
          end
        end
      end

      assign o_rdata    = pd_reg[OUT_REG-1];
      assign o_rd_valid = pv_reg[OUT_REG-1];
    end
  endgenerate

endmodule

// File: tb/tb_bram_bank.sv
// Bench for bram_bank: two instances (defaults, and MEM_MAX=200/write-first/output
// register) share one stimulus stream and are checked against a behavioural model.
module tb_bram_bank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  waddr = '0;
  logic [15:0] wdata = '0;
  logic        rd_en = 1'b0;
  logic [7:0]  raddr = '0;

  logic        rdy_a, vld_a, rdy_b, vld_b;
  logic [15:0] rdat_a, rdat_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bram_bank dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .o_ready(rdy_a),
    .i_wr_en(wr_en), .i_waddr(waddr), .i_wdata(wdata),
    .i_rd_en(rd_en), .i_raddr(raddr), .o_rdata(rdat_a), .o_rd_valid(vld_a)
  );

  bram_bank #(.MEM_MAX(200), .RD_MODE(1), .OUT_REG(1)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .o_ready(rdy_b),
    .i_wr_en(wr_en), .i_waddr(waddr), .i_wdata(wdata),
    .i_rd_en(rd_en), .i_raddr(raddr), .o_rdata(rdat_b), .o_rd_valid(vld_b)
  );

  function automatic int mm(int k);
    return (k == 0) ? 256 : 200;
  endfunction
  function automatic int lat(int k);
    return (k == 0) ? 1 : 2;
  endfunction
  function automatic bit wfirst(int k);
    return (k == 1);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: memory image, edges since reset release, and a schedule of
  // read results indexed by the edge number on which they become visible.
  bit [15:0] m_mem [2][256];
  int        e_cnt [2];
  bit        m_rdy [2];
  bit        ev    [2];
  bit [15:0] ed    [2];
  bit        sv    [2][8];
  bit [15:0] sd    [2][8];
  int        edge_n = 0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int k = 0; k < 2; k++) begin
          e_cnt[k] = 0; m_rdy[k] = 0; ev[k] = 0; ed[k] = '0;
          for (int s = 0; s < 8; s++) sv[k][s] = 0;
        end
      end else begin
        edge_n++;
        for (int k = 0; k < 2; k++) begin
          if (m_rdy[k]) begin
            if (rd_en) begin
              bit [15:0] d;
              int slot;
              if (int'(raddr) >= mm(k))                                  d = '0;
              else if (wfirst(k) && wr_en && waddr == raddr)             d = wdata;
              else                                                       d = m_mem[k][raddr];
              slot = (edge_n + lat(k) - 1) % 8;
              sv[k][slot] = 1; sd[k][slot] = d;
            end
            if (wr_en && int'(waddr) < mm(k)) m_mem[k][waddr] = wdata;
          end
          e_cnt[k]++;
          if (!m_rdy[k] && e_cnt[k] >= mm(k) + 1) begin
            m_rdy[k] = 1;
            for (int a = 0; a < 256; a++) m_mem[k][a] = '0;
          end
          ev[k] = sv[k][edge_n % 8];
          if (ev[k]) ed[k] = sd[k][edge_n % 8];
          sv[k][edge_n % 8] = 0;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("ready_a", {31'b0, rdy_a}, {31'b0, m_rdy[0]});
      chk("valid_a", {31'b0, vld_a}, {31'b0, ev[0]});
      chk("rdata_a", {16'b0, rdat_a}, {16'b0, ed[0]});
      chk("ready_b", {31'b0, rdy_b}, {31'b0, m_rdy[1]});
      chk("valid_b", {31'b0, vld_b}, {31'b0, ev[1]});
      chk("rdata_b", {16'b0, rdat_b}, {16'b0, ed[1]});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic op(bit we, logic [7:0] wa, logic [15:0] wd, bit re, logic [7:0] ra);
    wr_en = we; waddr = wa; wdata = wd; rd_en = re; raddr = ra;
    $display("[TB] txn wr=%0b waddr=0x%02h wdata=0x%04h rd=%0b raddr=0x%02h", we, wa, wd, re, ra);
    cyc();
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    int ra_edge, rb_edge;
    repeat (3) cyc();
    chk("rst_ready_a", {31'b0, rdy_a}, 32'd0);
    chk("rst_rdata_b", {16'b0, rdat_b}, 32'd0);
    chk("rst_valid_b", {31'b0, vld_b}, 32'd0);

    // Release, let the clear reach address 100, then reset again.
    rst_n = 1'b1;
    repeat (100) cyc();
    rst_n = 1'b0;
    #1;
    chk("midclr_ready_a", {31'b0, rdy_a}, 32'd0);
    repeat (2) cyc();
    rst_n = 1'b1;

    ra_edge = 0; rb_edge = 0;
    for (int i = 1; i <= 400; i++) begin
      if (i <= 150) begin
        wr_en = 1'b1; waddr = 8'(i); wdata = 16'hDEAD; rd_en = 1'b1; raddr = 8'(i);
      end else begin
        wr_en = 1'b0; rd_en = 1'b0;
      end
      cyc();
      if (ra_edge == 0 && rdy_a) ra_edge = i;
      if (rb_edge == 0 && rdy_b) rb_edge = i;
    end
    wr_en = 1'b0; rd_en = 1'b0;
    $display("[TB] txn ready edges a=%0d b=%0d", ra_edge, rb_edge);
    chk("ready_edge_a", ra_edge, 32'd257);
    chk("ready_edge_b", rb_edge, 32'd201);

    // Full read sweep: every word zero, junk writes during clear had no effect.
    for (int a = 0; a < 256; a++) op(0, 8'h00, 16'h0000, 1, 8'(a));
    cyc(); cyc();
    chk("sweep_last_b", {16'b0, rdat_b}, 32'h0000);

    op(1, 8'h12, 16'hBEEF, 0, 8'h00);
    op(0, 8'h00, 16'h0000, 1, 8'h12);
    chk("beef_valid_a", {31'b0, vld_a}, 32'd1);
    chk("beef_data_a", {16'b0, rdat_a}, 32'hBEEF);
    cyc();
    chk("beef_pulse_a", {31'b0, vld_a}, 32'd0);
    chk("beef_valid_b", {31'b0, vld_b}, 32'd1);
    chk("beef_data_b", {16'b0, rdat_b}, 32'hBEEF);

    op(1, 8'h34, 16'h1111, 0, 8'h00);
    op(1, 8'h34, 16'h2222, 1, 8'h34);
    chk("rdw_old_a", {16'b0, rdat_a}, 32'h1111);
    cyc();
    chk("rdw_new_b", {16'b0, rdat_b}, 32'h2222);
    op(0, 8'h00, 16'h0000, 1, 8'h34);
    chk("rdw_after_a", {16'b0, rdat_a}, 32'h2222);
    cyc();
    chk("rdw_after_b", {16'b0, rdat_b}, 32'h2222);

    op(1, 8'h01, 16'h0101, 0, 8'h00);
    op(1, 8'h02, 16'h0202, 0, 8'h00);
    op(1, 8'h03, 16'h0303, 0, 8'h00);
    op(0, 8'h00, 16'h0000, 1, 8'h01);
    chk("b2b1_a", {16'b0, rdat_a}, 32'h0101);
    op(0, 8'h00, 16'h0000, 1, 8'h02);
    chk("b2b2_a", {16'b0, rdat_a}, 32'h0202);
    chk("b2b1_b", {16'b0, rdat_b}, 32'h0101);
    op(0, 8'h00, 16'h0000, 1, 8'h03);
    chk("b2b3_a", {16'b0, rdat_a}, 32'h0303);
    chk("b2b2_b", {16'b0, rdat_b}, 32'h0202);
    cyc();
    chk("b2b3_b", {16'b0, rdat_b}, 32'h0303);

    // Address 220 is inside dut_a's range but outside dut_b's.
    op(1, 8'd220, 16'hAAAA, 0, 8'h00);
    op(0, 8'h00, 16'h0000, 1, 8'd220);
    chk("oor_data_a", {16'b0, rdat_a}, 32'hAAAA);
    cyc();
    chk("oor_valid_b", {31'b0, vld_b}, 32'd1);
    chk("oor_data_b", {16'b0, rdat_b}, 32'h0000);
    for (int a = 0; a < 200; a++) op(0, 8'h00, 16'h0000, 1, 8'(a));
    cyc(); cyc();

    op(1, 8'h40, 16'h0077, 1, 8'h12);
    chk("indep_a", {16'b0, rdat_a}, 32'hBEEF);
    op(0, 8'h00, 16'h0000, 1, 8'h40);
    chk("indep_b", {16'b0, rdat_b}, 32'hBEEF);
    chk("indep_wr_a", {16'b0, rdat_a}, 32'h0077);
    cyc();

    // Reset with a read still in dut_b's output stage.
    op(0, 8'h00, 16'h0000, 1, 8'h34);
    rst_n = 1'b0;
    #1;
    chk("flush_valid_b", {31'b0, vld_b}, 32'd0);
    chk("flush_data_b", {16'b0, rdat_b}, 32'h0000);
    chk("flush_ready_a", {31'b0, rdy_a}, 32'd0);
    repeat (3) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
